// File: rtl/mem_stage_px.sv
// Memory stage for the vector/pixel pipeline: routes ALU/load results to writeback,
// resolves branches, and collects GP pixels into a frame buffer drained over a stream port.
module mem_stage_px #(
    parameter int DATA_W    = 32,
    parameter int RD_W      = 7,
    parameter int ADDR_W    = 20,
    parameter int MEM_LAT   = 2,
    parameter int PIX_W     = 8,
    parameter int LANES     = 1,
    parameter int FRAME_PIX = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        opcode,
    input  logic [RD_W-1:0]   rd_in,
    input  logic [RD_W-1:0]   branch_in,
    input  logic [DATA_W-1:0] alu_result,
    output logic              dmem_req,
    output logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic              wr_en,
    output logic [DATA_W-1:0] result,
    output logic [RD_W-1:0]   rd_wb,
    output logic [RD_W-1:0]   branch_out,
    output logic              branch_taken,
    output logic              frame_done,
    output logic              pix_out_valid,
    input  logic              pix_out_ready,
    output logic [PIX_W-1:0]  pix_out_data
);

    localparam int PTR_W = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    localparam logic [4:0] OP_LV  = 5'd1;
    localparam logic [4:0] OP_ADD = 5'd2;
    localparam logic [4:0] OP_SUB = 5'd3;
    localparam logic [4:0] OP_MUL = 5'd4;
    localparam logic [4:0] OP_DIV = 5'd5;
    localparam logic [4:0] OP_CP  = 5'd6;
    localparam logic [4:0] OP_B   = 5'd7;
    localparam logic [4:0] OP_BEQ = 5'd8;
    localparam logic [4:0] OP_SLR = 5'd9;
    localparam logic [4:0] OP_GP  = 5'd10;

    typedef enum logic {
        ST_RUN,
        ST_CP_WAIT
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [RD_W-1:0]   r_cpRd;
    logic [RD_W-1:0]   r_cpBranch;
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic              r_draining;
    logic [PIX_W-1:0]  r_buf [FRAME_PIX];

    logic w_isGp;
    logic w_accept;
    logic w_fill;
    logic w_lastPix;

    // Drain is tracked apart from the FSM so a CP load never blocks pixel output;
    // only GP must wait for the buffer to empty.
    assign w_isGp    = (opcode == OP_GP);
    assign in_ready  = (r_state == ST_RUN) && !(r_draining && w_isGp);
    assign w_accept  = in_valid && in_ready;
    assign w_fill    = (r_wrPtr == PTR_W'(FRAME_PIX - LANES));
    assign w_lastPix = (r_rdPtr == PTR_W'(FRAME_PIX - 1));

    assign pix_out_valid = r_draining;
    assign pix_out_data  = r_draining ? r_buf[r_rdPtr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_cnt        <= '0;
            r_cpRd       <= '0;
            r_cpBranch   <= '0;
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
            r_draining   <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_addr    <= '0;
            wb_valid     <= 1'b0;
            wr_en        <= 1'b0;
            result       <= '0;
            rd_wb        <= '0;
            branch_out   <= '0;
            branch_taken <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            wr_en        <= 1'b0;
            result       <= '0;
            rd_wb        <= '0;
            branch_out   <= '0;
            branch_taken <= 1'b0;
            frame_done   <= 1'b0;
            dmem_req     <= 1'b0;

            if (r_draining && pix_out_ready) begin
                if (w_lastPix) begin
                    r_rdPtr    <= '0;
                    r_draining <= 1'b0;
                end else begin
                    r_rdPtr <= r_rdPtr + PTR_W'(1);
                end
            end

            case (r_state)
                ST_CP_WAIT: begin
                    // Load data is valid in the cycle where the count reaches MEM_LAT.
                    if (r_cnt == CNT_W'(MEM_LAT)) begin
                        wb_valid   <= 1'b1;
                        wr_en      <= 1'b1;
                        result     <= dmem_rdata;
                        rd_wb      <= r_cpRd;
                        branch_out <= r_cpBranch;
                        r_state    <= ST_RUN;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    if (w_accept) begin
                        case (opcode)
                            OP_LV, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SLR: begin
                                wb_valid <= 1'b1;
                                wr_en    <= 1'b1;
                                result   <= alu_result;
                                rd_wb    <= rd_in;
                            end
                            OP_CP: begin
                                dmem_req   <= 1'b1;
                                dmem_addr  <= alu_result[ADDR_W-1:0];
                                r_cpRd     <= rd_in;
                                r_cpBranch <= branch_in;
                                r_cnt      <= '0;
                                r_state    <= ST_CP_WAIT;
                            end
                            OP_B: begin
                                wb_valid     <= 1'b1;
                                branch_out   <= branch_in;
                                branch_taken <= 1'b1;
                            end
                            OP_BEQ: begin
                                wb_valid <= 1'b1;
                                if (alu_result == DATA_W'(1)) begin
                                    branch_out   <= branch_in;
                                    branch_taken <= 1'b1;
                                end
                            end
                            OP_GP: begin
                                wb_valid <= 1'b1;
                                if (w_fill) begin
                                    frame_done <= 1'b1;
                                    r_wrPtr    <= '0;
                                    r_draining <= 1'b1;
                                end else begin
                                    r_wrPtr <= r_wrPtr + PTR_W'(LANES);
                                end
                            end
                            default: begin
                                wb_valid <= 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    // Frame storage is deliberately unreset; stale pixels are never drained before a refill.
    always_ff @(posedge clk) begin
        if (w_accept && w_isGp) begin
            for (int k = 0; k < LANES; k++) begin
                r_buf[r_wrPtr + PTR_W'(k)] <= alu_result[k*PIX_W +: PIX_W];
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_px.sv
// Randomized self-checking bench for mem_stage_px against a queue-based transaction model
// (retire schedule, CP load timing, frame accumulation and drain order).
module tb_mem_stage_px;

    localparam int DATA_W    = 32;
    localparam int RD_W      = 7;
    localparam int ADDR_W    = 20;
    localparam int MEM_LAT   = 2;
    localparam int PIX_W     = 8;
    localparam int LANES     = 4;
    localparam int FRAME_PIX = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [4:0]        opcode = '0;
    logic [RD_W-1:0]   rd_in = '0;
    logic [RD_W-1:0]   branch_in = '0;
    logic [DATA_W-1:0] alu_result = '0;
    logic              dmem_req;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_rdata = '0;
    logic              wb_valid;
    logic              wr_en;
    logic [DATA_W-1:0] result;
    logic [RD_W-1:0]   rd_wb;
    logic [RD_W-1:0]   branch_out;
    logic              branch_taken;
    logic              frame_done;
    logic              pix_out_valid;
    logic              pix_out_ready = 1'b0;
    logic [PIX_W-1:0]  pix_out_data;

    mem_stage_px #(
        .DATA_W(DATA_W), .RD_W(RD_W), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT),
        .PIX_W(PIX_W), .LANES(LANES), .FRAME_PIX(FRAME_PIX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd_in(rd_in), .branch_in(branch_in), .alu_result(alu_result),
        .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wr_en(wr_en), .result(result), .rd_wb(rd_wb),
        .branch_out(branch_out), .branch_taken(branch_taken), .frame_done(frame_done),
        .pix_out_valid(pix_out_valid), .pix_out_ready(pix_out_ready), .pix_out_data(pix_out_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nCompared   = 0;
    int nMismatched = 0;

    function automatic logic [DATA_W-1:0] memFn(input logic [ADDR_W-1:0] a);
        if (a == 20'h00100) return 32'hDEAD_BEEF;
        return {a[11:0] ^ 12'hA5C, a};
    endfunction

    // Memory device: answers each observed request exactly MEM_LAT cycles later, junk otherwise.
    int                memDue[$];
    logic [ADDR_W-1:0] memAddr[$];
    always @(negedge clk) begin
        if (rst_n && dmem_req) begin
            memDue.push_back(cyc + MEM_LAT);
            memAddr.push_back(dmem_addr);
        end
    end
    always @(posedge clk) begin
        #1;
        while (memDue.size() > 0 && memDue[0] < cyc) begin
            void'(memDue.pop_front());
            void'(memAddr.pop_front());
        end
        if (memDue.size() > 0 && memDue[0] == cyc) begin
            dmem_rdata = memFn(memAddr[0]);
            void'(memDue.pop_front());
            void'(memAddr.pop_front());
        end else begin
            dmem_rdata = $urandom;
        end
    end

    // Reference model state
    logic              eWbValid, eWrEn, eBrTaken, eFrameDone, eReq;
    logic [DATA_W-1:0] eResult;
    logic [RD_W-1:0]   eRdWb, eBrOut;
    logic [ADDR_W-1:0] eAddr;
    bit                cpPending;
    int                cpAcceptEdge;
    logic [RD_W-1:0]   cpRd, cpBr;
    logic [DATA_W-1:0] cpData;
    logic [PIX_W-1:0]  frameQ[$];
    logic [PIX_W-1:0]  drainQ[$];
    bit                pixReady = 1'b1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic clearExpect();
        eWbValid = 0; eWrEn = 0; eBrTaken = 0; eFrameDone = 0; eReq = 0;
        eResult = '0; eRdWb = '0; eBrOut = '0; eAddr = '0;
    endtask

    task automatic checkCycle();
        checkOutput("wb_valid", 32'(wb_valid), 32'(eWbValid));
        checkOutput("wr_en", 32'(wr_en), 32'(eWrEn));
        checkOutput("result", 32'(result), 32'(eResult));
        checkOutput("rd_wb", 32'(rd_wb), 32'(eRdWb));
        checkOutput("branch_out", 32'(branch_out), 32'(eBrOut));
        checkOutput("branch_taken", 32'(branch_taken), 32'(eBrTaken));
        checkOutput("frame_done", 32'(frame_done), 32'(eFrameDone));
        checkOutput("dmem_req", 32'(dmem_req), 32'(eReq));
        if (eReq) checkOutput("dmem_addr", 32'(dmem_addr), 32'(eAddr));
        checkOutput("pix_valid", 32'(pix_out_valid), 32'(drainQ.size() > 0));
        if (drainQ.size() > 0) checkOutput("pix_data", 32'(pix_out_data), 32'(drainQ[0]));
    endtask

    // One clock cycle: check registered outputs, drive inputs, check in_ready, advance model.
    task automatic applyStimulus(input logic v, input logic [4:0] op, input logic [RD_W-1:0] rd,
                                 input logic [RD_W-1:0] br, input logic [DATA_W-1:0] alu,
                                 output bit acc);
        logic mReady;
        int   c;
        checkCycle();
        in_valid = v; opcode = op; rd_in = rd; branch_in = br; alu_result = alu;
        pix_out_ready = pixReady;
        #1;
        c = cyc;
        mReady = !(cpPending && c <= cpAcceptEdge + MEM_LAT) && !(drainQ.size() > 0 && op == 5'd10);
        checkOutput("in_ready", 32'(in_ready), 32'(mReady));
        acc = v && mReady;
        clearExpect();
        if (cpPending && c + 1 == cpAcceptEdge + MEM_LAT + 1) begin
            eWbValid = 1; eWrEn = 1; eResult = cpData; eRdWb = cpRd; eBrOut = cpBr;
            cpPending = 0;
        end
        if (drainQ.size() > 0 && pixReady) void'(drainQ.pop_front());
        if (acc) begin
            if (op == 5'd6) begin
                cpPending = 1; cpAcceptEdge = c + 1; cpRd = rd; cpBr = br;
                cpData = memFn(alu[ADDR_W-1:0]);
                eReq = 1; eAddr = alu[ADDR_W-1:0];
            end else begin
                eWbValid = 1;
                case (op)
                    5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd9: begin
                        eWrEn = 1; eResult = alu; eRdWb = rd;
                    end
                    5'd7: begin
                        eBrOut = br; eBrTaken = 1;
                    end
                    5'd8: begin
                        if (alu == 32'd1) begin eBrOut = br; eBrTaken = 1; end
                    end
                    5'd10: begin
                        for (int k = 0; k < LANES; k++) frameQ.push_back(alu[k*PIX_W +: PIX_W]);
                        if (frameQ.size() == FRAME_PIX) begin
                            eFrameDone = 1;
                            drainQ = frameQ;
                            frameQ.delete();
                        end
                    end
                    default: ;
                endcase
            end
        end
        @(negedge clk);
    endtask

    task automatic issueInstr(input logic [4:0] op, input logic [RD_W-1:0] rd,
                              input logic [RD_W-1:0] br, input logic [DATA_W-1:0] alu);
        bit acc;
        int tries;
        acc = 0;
        tries = 0;
        while (!acc && tries < 100) begin
            applyStimulus(1'b1, op, rd, br, alu, acc);
            tries++;
        end
        if (!acc) checkOutput("issue_timeout", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, '0, '0, '0, acc);
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        in_valid = 1'b0; opcode = '0;
        #1;
        cpPending = 0;
        frameQ.delete();
        drainQ.delete();
        clearExpect();
        checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("rst_result", 32'(result), 32'd0);
        checkOutput("rst_branch_taken", 32'(branch_taken), 32'd0);
        checkOutput("rst_dmem_req", 32'(dmem_req), 32'd0);
        checkOutput("rst_pix_valid", 32'(pix_out_valid), 32'd0);
        checkOutput("rst_pix_data", 32'(pix_out_data), 32'd0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit acc;
        logic [4:0] op;
        logic [DATA_W-1:0] alu;
        int r;
        @(negedge clk);
        applyReset();
        idle(2);

        $display("[TB] directed: ADD, CP, BEQ");
        issueInstr(5'd2, 7'd3, 7'd0, 32'h0000_0005);
        idle(1);
        issueInstr(5'd6, 7'd9, 7'd4, 32'h0000_0100);
        idle(5);
        issueInstr(5'd8, 7'd1, 7'h12, 32'd1);
        issueInstr(5'd8, 7'd1, 7'h12, 32'd0);
        issueInstr(5'd7, 7'd0, 7'h33, 32'd7);
        issueInstr(5'd15, 7'd5, 7'd5, 32'hFFFF_FFFF);

        $display("[TB] directed: frame fill and drain");
        pixReady = 1;
        for (int i = 0; i < 5; i++) begin
            r = 4 * i;
            alu = {8'(r + 3), 8'(r + 2), 8'(r + 1), 8'(r)};
            issueInstr(5'd10, 7'd0, 7'd0, alu);
        end
        idle(20);

        $display("[TB] random traffic with drain backpressure");
        for (int i = 0; i < 700; i++) begin
            pixReady = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 31);
            op = (r < 24) ? 5'(r % 11) : 5'(r);
            alu = (op == 5'd8) ? 32'($urandom_range(0, 2)) : 32'($urandom);
            applyStimulus(1'($urandom_range(0, 3) != 0), op, RD_W'($urandom_range(0, 127)),
                          RD_W'($urandom_range(0, 127)), alu, acc);
        end

        $display("[TB] reset during CP wait, partial frame and drain");
        pixReady = 1;
        issueInstr(5'd6, 7'd2, 7'd2, 32'($urandom));
        idle(1);
        applyReset();
        idle(3);
        issueInstr(5'd10, 7'd0, 7'd0, 32'hAABB_CCDD);
        issueInstr(5'd10, 7'd0, 7'd0, 32'h1122_3344);
        applyReset();
        for (int i = 0; i < 4; i++) issueInstr(5'd10, 7'd0, 7'd0, 32'($urandom));
        idle(3);
        applyReset();
        idle(2);
        for (int i = 0; i < 4; i++) begin
            r = 4 * i;
            alu = {8'(r + 3), 8'(r + 2), 8'(r + 1), 8'(r)};
            issueInstr(5'd10, 7'd0, 7'd0, alu);
        end
        for (int i = 0; i < 40; i++) begin
            pixReady = 1'($urandom_range(0, 1));
            op = ($urandom_range(0, 1) != 0) ? 5'd6 : 5'd2;
            applyStimulus(1'($urandom_range(0, 1)), op, RD_W'($urandom_range(0, 127)),
                          RD_W'($urandom_range(0, 127)), 32'($urandom), acc);
        end
        pixReady = 1;
        idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
